// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared writeback result type for the wb_arbiter slice
// AL_SIZE sets the active-list depth; defaults to 32 entries when not supplied.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package riscv_pkg;

   localparam int AL_IDX_W = $clog2(`AL_SIZE);

   typedef struct packed {
      logic [AL_IDX_W-1:0] al_idx;
      logic [31:0]         data;
      logic [5:0]          rd;
      logic                uses_rd;
   } wb_req_t;

endpackage

// File: rtl/wb_arb_pick.sv
// rtl/wb_arb_pick.sv - picks the first NUM_WB set bits of mask scanning upward from start
// (wrapping); grant[p] is one-hot for port p, last is the final index granted.
module wb_arb_pick #(
   parameter int NUM_REQ = 4,
   parameter int NUM_WB  = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]             mask,
   input  logic [IDX_W-1:0]               start,
   output logic [NUM_WB-1:0][NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]               last
);

   always_comb begin
      int cnt;
      int idx;
      grant = '0;
      last  = start;
      cnt   = 0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(start) + k) % NUM_REQ;
         if (mask[idx] && cnt < NUM_WB) begin
            grant[cnt][idx] = 1'b1;
            last            = IDX_W'(idx);
            cnt             = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: one holding buffer per requester feeding NUM_WB registered ports.
// WB_ARB_ROUND_ROBIN_EN selects rotating priority; otherwise lowest index wins.
module wb_arbiter
   import riscv_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_WB  = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][AL_IDX_W-1:0]    req_al_idx,
   input  logic [NUM_REQ-1:0][31:0]            req_data,
   input  logic [NUM_REQ-1:0][5:0]             req_rd,
   input  logic [NUM_REQ-1:0]                  req_uses_rd,
   output logic [NUM_WB-1:0]                   wb_valid,
   output logic [NUM_WB-1:0][AL_IDX_W-1:0]     wb_al_idx,
   output logic [NUM_WB-1:0][31:0]             wb_data,
   output logic [NUM_WB-1:0][5:0]              wb_rd,
   output logic [NUM_WB-1:0]                   wb_uses_rd
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   wb_req_t [NUM_REQ-1:0]          in_req;
   wb_req_t [NUM_REQ-1:0]          cand;
   wb_req_t [NUM_REQ-1:0]          buf_q;
   logic    [NUM_REQ-1:0]          buf_valid;
   logic    [NUM_REQ-1:0]          cand_valid;
   logic    [NUM_REQ-1:0]          mask;
   logic    [NUM_REQ-1:0]          granted;
   logic    [NUM_WB-1:0][NUM_REQ-1:0] grant;
   wb_req_t [NUM_WB-1:0]           port_next;
   wb_req_t [NUM_WB-1:0]           wb_q;
   logic    [IDX_W-1:0]            start;
   logic    [IDX_W-1:0]            last;

   assign req_ready  = ~buf_valid;
   assign cand_valid = buf_valid | req_valid;
   assign mask       = flush ? '0 : cand_valid;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         in_req[i].al_idx  = req_al_idx[i];
         in_req[i].data    = req_data[i];
         in_req[i].rd      = req_rd[i];
         in_req[i].uses_rd = req_uses_rd[i];
         cand[i]           = buf_valid[i] ? buf_q[i] : in_req[i];
      end
   end

   always_comb begin
      granted = '0;
      for (int p = 0; p < NUM_WB; p++) begin
         granted      = granted | grant[p];
         port_next[p] = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[p][i]) port_next[p] = cand[i];
         end
      end
   end

   wb_arb_pick #(
      .NUM_REQ (NUM_REQ),
      .NUM_WB  (NUM_WB),
      .IDX_W   (IDX_W)
   ) u_pick (
      .mask  (mask),
      .start (start),
      .grant (grant),
      .last  (last)
   );

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr;

   assign start = rr_ptr;

   // Any set mask bit implies at least one grant; flush forces mask to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (|mask) begin
         rr_ptr <= IDX_W'((int'(last) + 1) % NUM_REQ);
      end
   end
`else
   logic unused_last;

   assign start       = '0;
   assign unused_last = ^last;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_valid <= '0;
         buf_q     <= '0;
         wb_valid  <= '0;
         wb_q      <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            buf_valid[i] <= !flush && cand_valid[i] && !granted[i];
            // Load only into an empty buffer so a held result is never overwritten.
            if (!buf_valid[i] && req_valid[i]) buf_q[i] <= in_req[i];
         end
         for (int p = 0; p < NUM_WB; p++) begin
            wb_valid[p] <= |grant[p];
            if (|grant[p]) wb_q[p] <= port_next[p];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_WB; p++) begin
         wb_al_idx[p]  = wb_q[p].al_idx;
         wb_data[p]    = wb_q[p].data;
         wb_rd[p]      = wb_q[p].rd;
         wb_uses_rd[p] = wb_q[p].uses_rd;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed bench for wb_arbiter against a priority-list model
// Honours WB_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_wb_arbiter;
   import riscv_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int NUM_WB  = 2;

   logic                             clk = 1'b0;
   logic                             rst;
   logic                             flush;
   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ-1:0]               req_ready;
   logic [NUM_REQ-1:0][AL_IDX_W-1:0] req_al_idx;
   logic [NUM_REQ-1:0][31:0]         req_data;
   logic [NUM_REQ-1:0][5:0]          req_rd;
   logic [NUM_REQ-1:0]               req_uses_rd;
   logic [NUM_WB-1:0]                wb_valid;
   logic [NUM_WB-1:0][AL_IDX_W-1:0]  wb_al_idx;
   logic [NUM_WB-1:0][31:0]          wb_data;
   logic [NUM_WB-1:0][5:0]           wb_rd;
   logic [NUM_WB-1:0]                wb_uses_rd;

   wb_arbiter #(.NUM_REQ(NUM_REQ), .NUM_WB(NUM_WB)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_al_idx(req_al_idx), .req_data(req_data), .req_rd(req_rd), .req_uses_rd(req_uses_rd),
      .wb_valid(wb_valid), .wb_al_idx(wb_al_idx), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_uses_rd(wb_uses_rd)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: held results per requester, last values per port, priority start.
   logic              mv [NUM_REQ];
   wb_req_t           mb [NUM_REQ];
   logic [NUM_WB-1:0] ev;
   wb_req_t           ef [NUM_WB];
   int                mptr;
   logic [31:0]       sbq [NUM_REQ][$];
   bit                sb_on;
   int                gcnt [NUM_REQ];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_REQ; i++) begin
         mv[i] = 1'b0;
         mb[i] = '0;
         sbq[i].delete();
      end
      ev   = '0;
      for (int p = 0; p < NUM_WB; p++) ef[p] = '0;
      mptr = 0;
   endtask

   task automatic idle_inputs();
      flush       = 1'b0;
      req_valid   = '0;
      req_al_idx  = '0;
      req_data    = '0;
      req_rd      = '0;
      req_uses_rd = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic step();
      logic [NUM_REQ-1:0] exp_ready;
      logic [NUM_REQ-1:0] cv;
      logic [NUM_REQ-1:0] gr;
      wb_req_t            cd [NUM_REQ];
      int                 pend[$];
      int                 r;
      for (int i = 0; i < NUM_REQ; i++) begin
         exp_ready[i] = !mv[i];
         cv[i]        = mv[i] || req_valid[i];
         cd[i]        = mv[i] ? mb[i] : {req_al_idx[i], req_data[i], req_rd[i], req_uses_rd[i]};
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      for (int k = 0; k < NUM_REQ; k++)
         if (cv[(mptr + k) % NUM_REQ]) pend.push_back((mptr + k) % NUM_REQ);
      gr = '0;
      ev = '0;
      if (!flush) begin
         for (int p = 0; p < NUM_WB && p < pend.size(); p++) begin
            ev[p]        = 1'b1;
            ef[p]        = cd[pend[p]];
            gr[pend[p]]  = 1'b1;
`ifdef WB_ARB_ROUND_ROBIN_EN
            mptr = (pend[p] + 1) % NUM_REQ;
`endif
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (flush) sbq[i].delete();
         else if (sb_on && req_valid[i] && !mv[i]) sbq[i].push_back(req_data[i]);
         if (!flush && cv[i] && !gr[i]) begin
            mb[i] = cd[i];
            mv[i] = 1'b1;
         end else begin
            mv[i] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NUM_WB; p++) begin
         check("wb_valid", 64'(wb_valid[p]), 64'(ev[p]));
         check("wb_fields", 64'({wb_al_idx[p], wb_data[p], wb_rd[p], wb_uses_rd[p]}), 64'(ef[p]));
         if (wb_valid[p]) begin
            r = int'(wb_data[p][31:28]);
            if (r < NUM_REQ) gcnt[r]++;
            if (sb_on && r < NUM_REQ) begin
               check("sb_present", 64'(sbq[r].size() > 0), 64'd1);
               if (sbq[r].size() > 0) check("sb_order", 64'(wb_data[p]), 64'(sbq[r].pop_front()));
            end
         end
      end
   endtask

   initial begin
      logic [27:0] seq [NUM_REQ];
      int          exp_cnt [NUM_REQ];
      sb_on = 1'b0;
      do_reset();
      check("rst_ready", 64'(req_ready), 64'hF);
      check("rst_wb_valid", 64'(wb_valid), 64'h0);
      check("rst_wb_fields", 64'({wb_al_idx, wb_data, wb_rd, wb_uses_rd}), 64'h0);

      // Two sparse requesters land on ports 0 and 1 together.
      req_valid   = 4'b0101;
      req_data[0] = 32'hA;
      req_data[2] = 32'hB;
      step();
      check("s1_wb0", 64'(wb_data[0]), 64'hA);
      check("s1_wb1", 64'(wb_data[1]), 64'hB);
      check("s1_valid", 64'(wb_valid), 64'h3);
      check("s1_ready", 64'(req_ready), 64'hF);
      idle_inputs();
      step();

      // Four at once: two granted, two held for the following cycle.
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) req_data[i] = 32'(i + 1);
      step();
      check("s2_c1_wb0", 64'(wb_data[0]), 64'h1);
      check("s2_c1_wb1", 64'(wb_data[1]), 64'h2);
      check("s2_c1_ready", 64'(req_ready), 64'h3);
      idle_inputs();
      step();
      check("s2_c2_wb0", 64'(wb_data[0]), 64'h3);
      check("s2_c2_wb1", 64'(wb_data[1]), 64'h4);
      check("s2_c2_valid", 64'(wb_valid), 64'h3);

      // Continuous contention from all four requesters over four cycles.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;
      req_valid = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) req_data[i] = {4'(i), 28'h0};
      repeat (4) step();
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_cnt = '{2, 2, 2, 2};
`else
      exp_cnt = '{4, 4, 0, 0};
`endif
      for (int i = 0; i < NUM_REQ; i++) check("s3_grants", 64'(gcnt[i]), 64'(exp_cnt[i]));

      // Flush with buffers 2 and 3 full: nothing held may ever emerge.
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) req_data[i] = 32'h20 + 32'(i);
      step();
      check("s4_held", 64'(req_ready), 64'h3);
      flush = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) req_data[i] = 32'h30 + 32'(i);
      step();
      check("s4_valid", 64'(wb_valid), 64'h0);
      check("s4_ready", 64'(req_ready), 64'hF);
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         step();
         check("s4_quiet", 64'(wb_valid), 64'h0);
      end

      // Asynchronous reset between edges with a result held.
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) req_data[i] = 32'h40 + 32'(i);
      step();
      step();
      idle_inputs();
      #2 rst = 1'b1;
      #1;
      check("s5_ready", 64'(req_ready), 64'hF);
      check("s5_valid", 64'(wb_valid), 64'h0);
      check("s5_data", 64'(wb_data), 64'h0);
      #1 rst = 1'b0;
      model_clear();
      step();
      check("s5_after", 64'(wb_valid), 64'h0);

      // Random traffic with occasional flushes; scoreboard tracks each requester.
      do_reset();
      sb_on = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) seq[i] = '0;
      for (int c = 0; c < 10000; c++) begin
         req_valid = NUM_REQ'($urandom);
         flush     = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i]    = {4'(i), seq[i]};
            seq[i]         = seq[i] + 28'd1;
            req_al_idx[i]  = AL_IDX_W'($urandom);
            req_rd[i]      = 6'($urandom);
            req_uses_rd[i] = 1'($urandom);
         end
         step();
      end
      idle_inputs();
      repeat (NUM_REQ + 2) step();
      for (int i = 0; i < NUM_REQ; i++) check("sb_drained", 64'(sbq[i].size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
